// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order store FIFO between LSU and dcache; loads wait for drain,
//            or hit in the buffer when STORE_BUFFER_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_valid,
  input  logic        up_op,
  input  logic [31:0] up_addr,
  input  logic [3:0]  up_awstrb,
  input  logic [31:0] up_wdata,
  output logic        up_ready,
  output logic        up_rvalid,
  output logic [31:0] up_rdata,
  output logic        dc_valid,
  output logic        dc_op,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_awstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_ready,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata
);

  localparam logic [0:0]     S_IDLE     = 1'b0;
  localparam logic [0:0]     S_LD_WAIT  = 1'b1;
  localparam logic [PTR_W:0] c_FULL_CNT = DEPTH[PTR_W:0];

  logic [31:0]      r_addr [DEPTH];
  logic [3:0]       r_strb [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic [0:0]       r_state, w_state_nxt;

  logic        w_full, w_empty, w_enq, w_deq, w_is_load;
  logic        w_fwd_hit;
  logic [31:0] w_fwd_data;

  assign w_full    = (r_count == c_FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_is_load = up_valid && !up_op;
  assign w_enq     = up_valid && up_op && !w_full;
  // Draining is only allowed in IDLE so an outstanding load keeps its place.
  assign w_deq     = (r_state == S_IDLE) && !w_empty && dc_ready;

`ifdef STORE_BUFFER_FWD_EN
  logic [PTR_W-1:0] w_slot_idx [DEPTH];
  logic [DEPTH-1:0] w_slot_hit;
  logic             w_match_any;
  logic [3:0]       w_match_strb;
  logic [31:0]      w_match_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_slot_idx[g] = r_head + PTR_W'(g);
    assign w_slot_hit[g] = ((PTR_W+1)'(g) < r_count) &&
                           (r_addr[w_slot_idx[g]][31:2] == up_addr[31:2]);
  end

  // Slots are scanned oldest to youngest, so the last hit wins.
  always_comb begin
    w_match_any  = 1'b0;
    w_match_strb = '0;
    w_match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_slot_hit[i]) begin
        w_match_any  = 1'b1;
        w_match_strb = r_strb[w_slot_idx[i]];
        w_match_data = r_data[w_slot_idx[i]];
      end
    end
  end

  assign w_fwd_hit  = w_match_any && ((w_match_strb & up_awstrb) == up_awstrb);
  assign w_fwd_data = w_match_data & {{8{w_match_strb[3]}}, {8{w_match_strb[2]}},
                                      {8{w_match_strb[1]}}, {8{w_match_strb[0]}}};
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= up_addr;
      r_strb[r_tail] <= up_awstrb;
      r_data[r_tail] <= up_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (w_is_load && w_empty && dc_ready && !dc_rvalid) w_state_nxt = S_LD_WAIT;
      S_LD_WAIT:
        if (dc_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    up_ready  = w_enq;
    up_rvalid = 1'b0;
    up_rdata  = '0;
    dc_valid  = 1'b0;
    dc_op     = 1'b0;
    dc_addr   = '0;
    dc_awstrb = '0;
    dc_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          dc_valid  = 1'b1;
          dc_op     = 1'b1;
          dc_addr   = r_addr[r_head];
          dc_awstrb = r_strb[r_head];
          dc_wdata  = r_data[r_head];
        end
        if (w_is_load) begin
          if (w_fwd_hit) begin
            up_ready  = 1'b1;
            up_rvalid = 1'b1;
            up_rdata  = w_fwd_data;
          end else if (w_empty) begin
            dc_valid  = 1'b1;
            dc_op     = 1'b0;
            dc_addr   = up_addr;
            dc_awstrb = up_awstrb;
            up_ready  = dc_ready;
            if (dc_ready && dc_rvalid) begin
              up_rvalid = 1'b1;
              up_rdata  = dc_rdata;
            end
          end
        end
      end
      S_LD_WAIT: begin
        up_rvalid = dc_rvalid;
        up_rdata  = dc_rvalid ? dc_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Directed self-checking bench for store_buffer (either build of
//            STORE_BUFFER_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        up_valid, up_op;
  logic [31:0] up_addr, up_wdata;
  logic [3:0]  up_awstrb;
  logic        up_ready, up_rvalid;
  logic [31:0] up_rdata;
  logic        dc_valid, dc_op;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_awstrb;
  logic        dc_ready, dc_rvalid;
  logic [31:0] dc_rdata;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .up_valid(up_valid), .up_op(up_op), .up_addr(up_addr), .up_awstrb(up_awstrb),
    .up_wdata(up_wdata), .up_ready(up_ready), .up_rvalid(up_rvalid), .up_rdata(up_rdata),
    .dc_valid(dc_valid), .dc_op(dc_op), .dc_addr(dc_addr), .dc_awstrb(dc_awstrb),
    .dc_wdata(dc_wdata), .dc_ready(dc_ready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    up_valid = 1'b0; up_op = 1'b0; up_addr = '0; up_awstrb = '0; up_wdata = '0;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    up_valid = 1'b1; up_op = 1'b1; up_addr = a; up_awstrb = s; up_wdata = d;
  endtask

  task automatic drive_ld(input logic [31:0] a, input logic [3:0] s);
    up_valid = 1'b1; up_op = 1'b0; up_addr = a; up_awstrb = s; up_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive_idle(); dc_ready = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0;
    tick(); tick();
    reset = 1'b0; settle();
    checks++; if (dc_valid !== 1'b0) begin errors++; $display("FAIL rst_dc_valid: got %0b exp 0", dc_valid); end
    checks++; if (up_rvalid !== 1'b0) begin errors++; $display("FAIL rst_up_rvalid: got %0b exp 0", up_rvalid); end
    checks++; if (up_rdata !== 32'h0) begin errors++; $display("FAIL rst_up_rdata: got %08h exp 0", up_rdata); end
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL rst_up_ready: got %0b exp 0", up_ready); end
    checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", dut.r_count); end
  endtask

  task automatic test_single_store();
    dc_ready = 1'b1;
    drive_st(32'h100, 4'hF, 32'hDEADBEEF); settle();
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %0b exp 1", up_ready); end
    checks++; if (dc_valid !== 1'b0) begin errors++; $display("FAIL st_dc_idle: got %0b exp 0", dc_valid); end
    tick(); drive_idle(); settle();
    checks++; if (dc_valid !== 1'b1 || dc_op !== 1'b1) begin errors++; $display("FAIL st_drain_vld_op: got %0b/%0b exp 1/1", dc_valid, dc_op); end
    checks++; if (dc_addr !== 32'h100) begin errors++; $display("FAIL st_drain_addr: got %08h exp 00000100", dc_addr); end
    checks++; if (dc_wdata !== 32'hDEADBEEF || dc_awstrb !== 4'hF) begin errors++; $display("FAIL st_drain_data: got %08h/%h exp deadbeef/f", dc_wdata, dc_awstrb); end
    checks++; if (up_rvalid !== 1'b0) begin errors++; $display("FAIL st_no_rvalid: got %0b exp 0", up_rvalid); end
    tick(); settle();
    checks++; if (dut.r_count !== 3'd0 || dc_valid !== 1'b0) begin errors++; $display("FAIL st_empty: got count %0d dc_valid %0b exp 0/0", dut.r_count, dc_valid); end
  endtask

  task automatic test_fill();
    dc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_st(32'h500 + 32'(4*k), 4'hF, 32'hA0 + 32'(k)); settle();
      checks++; if (up_ready !== (k < 4)) begin errors++; $display("FAIL fill_ready[%0d]: got %0b exp %0b", k, up_ready, (k < 4)); end
      tick();
    end
    drive_idle(); dc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (dc_valid !== 1'b1 || dc_addr !== 32'h500 + 32'(4*k)) begin errors++; $display("FAIL fill_order_addr[%0d]: got %0b/%08h exp 1/%08h", k, dc_valid, dc_addr, 32'h500 + 32'(4*k)); end
      checks++; if (dc_wdata !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL fill_order_data[%0d]: got %08h exp %08h", k, dc_wdata, 32'hA0 + 32'(k)); end
      tick();
    end
    settle();
    checks++; if (dut.r_count !== 3'd0 || dc_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got count %0d dc_valid %0b exp 0/0", dut.r_count, dc_valid); end
  endtask

  task automatic test_wrap();
    // Head/tail sit at index 1 here, so C lands in slot 3 and D wraps to slot 0.
    dc_ready = 1'b0;
    drive_st(32'h300, 4'hF, 32'h1); tick();
    drive_st(32'h304, 4'hF, 32'h2); tick();
    dc_ready = 1'b1;
    drive_st(32'h308, 4'hF, 32'h3); settle();
    checks++; if (up_ready !== 1'b1 || dc_addr !== 32'h300) begin errors++; $display("FAIL wrap_c: got ready %0b addr %08h exp 1/00000300", up_ready, dc_addr); end
    tick();
    checks++; if (dut.r_count !== 3'd2 || dut.r_tail !== 2'd0) begin errors++; $display("FAIL wrap_ptr: got count %0d tail %0d exp 2/0", dut.r_count, dut.r_tail); end
    drive_st(32'h30C, 4'hF, 32'h4); settle();
    checks++; if (dc_addr !== 32'h304) begin errors++; $display("FAIL wrap_d_addr: got %08h exp 00000304", dc_addr); end
    tick();
    checks++; if (dut.r_count !== 3'd2) begin errors++; $display("FAIL wrap_count: got %0d exp 2", dut.r_count); end
    drive_idle(); settle();
    checks++; if (dc_addr !== 32'h308) begin errors++; $display("FAIL wrap_drain3: got %08h exp 00000308", dc_addr); end
    tick(); settle();
    checks++; if (dc_addr !== 32'h30C || dc_wdata !== 32'h4) begin errors++; $display("FAIL wrap_drain4: got %08h/%08h exp 0000030c/00000004", dc_addr, dc_wdata); end
    tick(); settle();
    checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d exp 0", dut.r_count); end
  endtask

  task automatic test_load_after_stores();
    dc_ready = 1'b0;
    drive_st(32'h400, 4'hF, 32'h11); tick();
    drive_st(32'h404, 4'hF, 32'h22); tick();
    drive_ld(32'h200, 4'hF); dc_ready = 1'b1; settle();
    checks++; if (up_ready !== 1'b0 || dc_op !== 1'b1 || dc_addr !== 32'h400) begin errors++; $display("FAIL ld_stall0: got ready %0b op %0b addr %08h exp 0/1/00000400", up_ready, dc_op, dc_addr); end
    tick(); settle();
    checks++; if (up_ready !== 1'b0 || dc_op !== 1'b1 || dc_addr !== 32'h404) begin errors++; $display("FAIL ld_stall1: got ready %0b op %0b addr %08h exp 0/1/00000404", up_ready, dc_op, dc_addr); end
    tick(); settle();
    checks++; if (dc_valid !== 1'b1 || dc_op !== 1'b0 || dc_addr !== 32'h200 || up_ready !== 1'b1) begin errors++; $display("FAIL ld_issue: got vld %0b op %0b addr %08h ready %0b exp 1/0/00000200/1", dc_valid, dc_op, dc_addr, up_ready); end
    tick(); drive_idle(); dc_ready = 1'b0; settle();
    checks++; if (dc_valid !== 1'b0 || up_rvalid !== 1'b0) begin errors++; $display("FAIL ld_wait: got dc_valid %0b rvalid %0b exp 0/0", dc_valid, up_rvalid); end
    tick(); dc_rvalid = 1'b1; dc_rdata = 32'h12345678; settle();
    checks++; if (up_rvalid !== 1'b1 || up_rdata !== 32'h12345678) begin errors++; $display("FAIL ld_data: got %0b/%08h exp 1/12345678", up_rvalid, up_rdata); end
    tick(); dc_rvalid = 1'b0; dc_rdata = 32'h0; settle();
    checks++; if (up_rvalid !== 1'b0 || up_rdata !== 32'h0) begin errors++; $display("FAIL ld_one_cycle: got %0b/%08h exp 0/0", up_rvalid, up_rdata); end
  endtask

  task automatic test_load_same_cycle();
    dc_ready = 1'b1; dc_rvalid = 1'b1; dc_rdata = 32'hCAFEF00D;
    drive_ld(32'h240, 4'hF); settle();
    checks++; if (up_ready !== 1'b1 || up_rvalid !== 1'b1 || up_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ldsc_data: got %0b/%0b/%08h exp 1/1/cafef00d", up_ready, up_rvalid, up_rdata); end
    tick(); dc_rvalid = 1'b0; dc_rdata = '0;
    drive_st(32'h244, 4'hF, 32'h55); tick(); drive_idle(); settle();
    // A drain being presented proves the FSM stayed in IDLE.
    checks++; if (dc_valid !== 1'b1 || dc_op !== 1'b1 || dc_addr !== 32'h244) begin errors++; $display("FAIL ldsc_idle: got %0b/%0b/%08h exp 1/1/00000244", dc_valid, dc_op, dc_addr); end
    tick();
  endtask

  task automatic test_forward();
`ifdef STORE_BUFFER_FWD_EN
    dc_ready = 1'b0;
    drive_st(32'h104, 4'hF, 32'h11111111); tick();
    drive_st(32'h104, 4'b0011, 32'hFFFFABCD); tick();
    drive_ld(32'h104, 4'b0001); settle();
    checks++; if (up_ready !== 1'b1 || up_rvalid !== 1'b1 || up_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL fwd_hit: got %0b/%0b/%08h exp 1/1/0000abcd", up_ready, up_rvalid, up_rdata); end
    checks++; if (dc_op !== 1'b1) begin errors++; $display("FAIL fwd_no_dc_read: got op %0b exp 1", dc_op); end
    tick();
    checks++; if (dut.r_count !== 3'd2) begin errors++; $display("FAIL fwd_fifo_kept: got %0d exp 2", dut.r_count); end
    drive_ld(32'h104, 4'b0100); settle();
    checks++; if (up_ready !== 1'b0 || up_rvalid !== 1'b0) begin errors++; $display("FAIL fwd_partial: got %0b/%0b exp 0/0", up_ready, up_rvalid); end
    dc_ready = 1'b1; tick(); settle();
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL fwd_partial_young: got %0b exp 0", up_ready); end
    tick(); dc_rvalid = 1'b1; dc_rdata = 32'h00550000; settle();
    checks++; if (dc_op !== 1'b0 || dc_addr !== 32'h104 || up_ready !== 1'b1 || up_rdata !== 32'h00550000) begin errors++; $display("FAIL fwd_passthru: got op %0b addr %08h ready %0b data %08h exp 0/00000104/1/00550000", dc_op, dc_addr, up_ready, up_rdata); end
`else
    dc_ready = 1'b0;
    drive_st(32'h104, 4'b0011, 32'hFFFFABCD); tick();
    drive_ld(32'h104, 4'b0001); settle();
    checks++; if (up_ready !== 1'b0 || up_rvalid !== 1'b0 || dc_op !== 1'b1) begin errors++; $display("FAIL nofwd_stall: got %0b/%0b/%0b exp 0/0/1", up_ready, up_rvalid, dc_op); end
    dc_ready = 1'b1; tick(); dc_rvalid = 1'b1; dc_rdata = 32'h000000CD; settle();
    checks++; if (dc_op !== 1'b0 || up_ready !== 1'b1 || up_rdata !== 32'h000000CD) begin errors++; $display("FAIL nofwd_passthru: got op %0b ready %0b data %08h exp 0/1/000000cd", dc_op, up_ready, up_rdata); end
`endif
    tick(); drive_idle(); dc_rvalid = 1'b0; dc_rdata = '0;
  endtask

  task automatic test_reset_mid();
    dc_ready = 1'b1; dc_rvalid = 1'b0;
    drive_ld(32'h600, 4'hF); settle();
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rm_ld_ready: got %0b exp 1", up_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive_st(32'h700 + 32'(4*k), 4'hF, 32'(k)); settle();
      checks++; if (up_ready !== 1'b1 || dc_valid !== 1'b0) begin errors++; $display("FAIL rm_st[%0d]: got ready %0b dc_valid %0b exp 1/0", k, up_ready, dc_valid); end
      tick();
    end
    drive_idle(); reset = 1'b1; tick(); reset = 1'b0; settle();
    checks++; if (dut.r_count !== 3'd0 || dc_valid !== 1'b0 || up_rvalid !== 1'b0) begin errors++; $display("FAIL rm_after: got count %0d dc_valid %0b rvalid %0b exp 0/0/0", dut.r_count, dc_valid, up_rvalid); end
    dc_rvalid = 1'b1; dc_rdata = 32'hBAD0BAD0; settle();
    checks++; if (up_rvalid !== 1'b0 || up_rdata !== 32'h0) begin errors++; $display("FAIL rm_late_rvalid: got %0b/%08h exp 0/0", up_rvalid, up_rdata); end
    tick(); dc_rvalid = 1'b0; dc_rdata = '0;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_wrap();
    test_load_after_stores();
    test_load_same_cycle();
    test_forward();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
